// File: rtl/inst_store_cu.sv
// inst_store_cu: serialises whole MIPS/Y86 instructions into little-endian
// byte writes to the instruction memory, one byte per cycle, while tracking
// a running write pointer and a completed-instruction count.
module inst_store_cu #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [47:0]      in_inst,
  input  logic             in_mode,
  input  logic [31:0]      in_addr,
  input  logic             in_seq,
  input  logic             flush,
  input  logic             wr_stall,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_datain,
  output logic [31:0]      next_addr,
  output logic             busy,
  output logic [CNT_W-1:0] inst_count
);

  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_e;

  state_e           state_q;
  logic [2:0]       off_q;
  logic [2:0]       len_q;
  logic [31:0]      base_q;
  logic [47:0]      inst_q;
  logic [31:0]      next_addr_q;
  logic [CNT_W-1:0] cnt_q;

  logic             last;
  logic             accept;
  logic [31:0]      base_plus_len;
  logic [31:0]      seq_base;
  logic [2:0]       in_len;

  // Instruction length in bytes: MIPS is fixed, Y86 is decoded from the
  // opcode nibble of byte 0.
  function automatic logic [2:0] inst_len(input logic mode, input logic [3:0] nib);
    logic [2:0] l;
    if (!mode) l = 3'd4;
    else begin
      case (nib)
        4'h2, 4'h6, 4'hA, 4'hB: l = 3'd2;
        4'h7, 4'h8:             l = 3'd5;
        4'h3, 4'h4, 4'h5:       l = 3'd6;
        default:                l = 3'd1;
      endcase
    end
    return l;
  endfunction

  assign in_len        = inst_len(in_mode, in_inst[7:4]);
  assign busy          = (state_q == S_WRITE);
  assign base_plus_len = base_q + {29'd0, len_q};
  // Final byte of the current instruction goes out this cycle.
  assign last          = busy && (off_q == len_q - 3'd1) && !wr_stall && !flush;
  assign in_ready      = !flush && (!busy || last);
  assign accept        = in_valid && in_ready;
  // On a back-to-back accept the registered next_addr is still stale, so the
  // sequential base must come from the instruction finishing right now.
  assign seq_base      = last ? base_plus_len : next_addr_q;

  assign mem_we        = busy && !wr_stall && !flush;
  assign mem_addr      = base_q + {29'd0, off_q};
  assign next_addr     = next_addr_q;
  assign inst_count    = cnt_q;

  // Byte select for the current offset (little-endian).
  always_comb begin
    mem_datain = 8'd0;
    case (off_q)
      3'd0:    mem_datain = inst_q[7:0];
      3'd1:    mem_datain = inst_q[15:8];
      3'd2:    mem_datain = inst_q[23:16];
      3'd3:    mem_datain = inst_q[31:24];
      3'd4:    mem_datain = inst_q[39:32];
      3'd5:    mem_datain = inst_q[47:40];
      default: mem_datain = 8'd0;
    endcase
  end

  // Control FSM plus write-pointer, offset and completion bookkeeping.
  // The offset is not advanced on the last byte so address/data keep showing
  // the final write while idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      off_q       <= 3'd0;
      len_q       <= 3'd1;
      base_q      <= 32'd0;
      inst_q      <= 48'd0;
      next_addr_q <= 32'd0;
      cnt_q       <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      off_q   <= 3'd0;
    end else begin
      if (last) begin
        next_addr_q <= base_plus_len;
        cnt_q       <= cnt_q + CNT_W'(1);
        state_q     <= S_IDLE;
      end else if (busy && !wr_stall) begin
        off_q <= off_q + 3'd1;
      end
      if (accept) begin
        base_q  <= in_seq ? seq_base : in_addr;
        inst_q  <= in_inst;
        len_q   <= in_len;
        off_q   <= 3'd0;
        state_q <= S_WRITE;
      end
    end
  end

endmodule

// File: tb/tb_inst_store_cu.sv
// Directed bench for inst_store_cu: inputs change on the falling edge,
// outputs are checked 1 time unit later, well before the next rising edge.
module tb_inst_store_cu;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_mode, in_seq, flush, wr_stall;
  logic [47:0] in_inst;
  logic [31:0] in_addr;
  logic        in_ready, mem_we, busy;
  logic [31:0] mem_addr, next_addr;
  logic [7:0]  mem_datain;
  logic [15:0] inst_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_store_cu #(.CNT_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_mode(in_mode), .in_addr(in_addr), .in_seq(in_seq),
    .flush(flush), .wr_stall(wr_stall),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .next_addr(next_addr), .busy(busy), .inst_count(inst_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and apply a new input vector.
  task automatic cyc(input logic v, input logic [47:0] inst, input logic mode,
                     input logic [31:0] addr, input logic seq,
                     input logic stall, input logic fl);
    @(negedge clk);
    in_valid = v; in_inst = inst; in_mode = mode; in_addr = addr;
    in_seq = seq; wr_stall = stall; flush = fl;
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 48'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic exp_wr(input string tag, input logic [31:0] a, input logic [7:0] d);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_data"}, {24'd0, mem_datain}, {24'd0, d});
  endtask

  task automatic exp_done(input string tag, input logic [31:0] na, input logic [15:0] cnt);
    chk({tag, "_we0"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_busy0"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_next"}, next_addr, na);
    chk({tag, "_cnt"}, {16'd0, inst_count}, {16'd0, cnt});
  endtask

  initial begin
    resetn = 1'b0;
    in_valid = 0; in_inst = 0; in_mode = 0; in_addr = 0;
    in_seq = 0; wr_stall = 0; flush = 0;
    #12;
    // Reset state
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", {24'd0, mem_datain}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_next", next_addr, 32'd0);
    chk("rst_cnt", {16'd0, inst_count}, 32'd0);
    @(negedge clk); resetn = 1'b1;

    // 1: MIPS word at 0x100
    cyc(1, 48'h0000_AABBCCDD, 0, 32'h100, 0, 0, 0);
    chk("t1_rdy", {31'd0, in_ready}, 32'd1);
    idle_cyc(); exp_wr("t1_b0", 32'h100, 8'hDD);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    idle_cyc(); exp_wr("t1_b1", 32'h101, 8'hCC);
    idle_cyc(); exp_wr("t1_b2", 32'h102, 8'hBB);
    idle_cyc(); exp_wr("t1_b3", 32'h103, 8'hAA);
    idle_cyc(); exp_done("t1", 32'h104, 16'd1);

    // 2: Y86 L=6 at 0x200, then a 1-byte instruction streamed with in_seq
    cyc(1, 48'h0000_0000_5A30, 1, 32'h200, 0, 0, 0);
    cyc(1, 48'h0, 1, 32'hDEAD, 1, 0, 0); exp_wr("t2_b0", 32'h200, 8'h30);
    chk("t2_rdy0", {31'd0, in_ready}, 32'd0);
    cyc(1, 48'h0, 1, 32'hDEAD, 1, 0, 0); exp_wr("t2_b1", 32'h201, 8'h5A);
    cyc(1, 48'h0, 1, 32'hDEAD, 1, 0, 0); exp_wr("t2_b2", 32'h202, 8'h00);
    cyc(1, 48'h0, 1, 32'hDEAD, 1, 0, 0); exp_wr("t2_b3", 32'h203, 8'h00);
    cyc(1, 48'h0, 1, 32'hDEAD, 1, 0, 0); exp_wr("t2_b4", 32'h204, 8'h00);
    chk("t2_rdy4", {31'd0, in_ready}, 32'd0);
    cyc(1, 48'h0, 1, 32'hDEAD, 1, 0, 0); exp_wr("t2_b5", 32'h205, 8'h00);
    chk("t2_rdy5", {31'd0, in_ready}, 32'd1);
    idle_cyc(); exp_wr("t2_b6", 32'h206, 8'h00);
    chk("t2_busy6", {31'd0, busy}, 32'd1);
    idle_cyc(); exp_done("t2", 32'h207, 16'd3);

    // 3: stall for 2 cycles after the 2nd byte
    cyc(1, 48'h0000_11223344, 0, 32'h300, 0, 0, 0);
    idle_cyc(); exp_wr("t3_b0", 32'h300, 8'h44);
    idle_cyc(); exp_wr("t3_b1", 32'h301, 8'h33);
    cyc(0, 48'h0, 0, 32'h0, 0, 1, 0);
    chk("t3_st0_we", {31'd0, mem_we}, 32'd0);
    chk("t3_st0_addr", mem_addr, 32'h302);
    chk("t3_st0_data", {24'd0, mem_datain}, 32'h22);
    cyc(0, 48'h0, 0, 32'h0, 0, 1, 0);
    chk("t3_st1_we", {31'd0, mem_we}, 32'd0);
    chk("t3_st1_addr", mem_addr, 32'h302);
    idle_cyc(); exp_wr("t3_b2", 32'h302, 8'h22);
    idle_cyc(); exp_wr("t3_b3", 32'h303, 8'h11);
    idle_cyc(); exp_done("t3", 32'h304, 16'd4);

    // 4: Y86 L=5 at 0x40, flushed during the 3rd byte
    cyc(1, 48'h00_0055_443370, 1, 32'h40, 0, 0, 0);
    idle_cyc(); exp_wr("t4_b0", 32'h40, 8'h70);
    idle_cyc(); exp_wr("t4_b1", 32'h41, 8'h33);
    cyc(1, 48'h0, 0, 32'h0, 0, 0, 1);
    chk("t4_fl_we", {31'd0, mem_we}, 32'd0);
    chk("t4_fl_rdy", {31'd0, in_ready}, 32'd0);
    idle_cyc(); exp_done("t4", 32'h304, 16'd4);
    idle_cyc(); chk("t4_after_we", {31'd0, mem_we}, 32'd0);

    // 5: address wrap
    cyc(1, 48'h0000_87654321, 0, 32'hFFFF_FFFE, 0, 0, 0);
    idle_cyc(); exp_wr("t5_b0", 32'hFFFF_FFFE, 8'h21);
    idle_cyc(); exp_wr("t5_b1", 32'hFFFF_FFFF, 8'h43);
    idle_cyc(); exp_wr("t5_b2", 32'h0000_0000, 8'h65);
    idle_cyc(); exp_wr("t5_b3", 32'h0000_0001, 8'h87);
    idle_cyc(); exp_done("t5", 32'h2, 16'd5);

    // 6: reset asserted during the 2nd byte
    cyc(1, 48'h0000_A1B2C3D4, 0, 32'h500, 0, 0, 0);
    idle_cyc(); exp_wr("t6_b0", 32'h500, 8'hD4);
    idle_cyc(); exp_wr("t6_b1", 32'h501, 8'hC3);
    resetn = 1'b0; #1;
    chk("t6_rst_we", {31'd0, mem_we}, 32'd0);
    chk("t6_rst_addr", mem_addr, 32'd0);
    chk("t6_rst_data", {24'd0, mem_datain}, 32'd0);
    exp_done("t6_rst", 32'h0, 16'd0);
    @(negedge clk); resetn = 1'b1;
    cyc(1, 48'h0000_0A0B0C0D, 0, 32'h9999, 1, 0, 0);
    idle_cyc(); exp_wr("t6_b0n", 32'h0, 8'h0D);
    idle_cyc(); exp_wr("t6_b1n", 32'h1, 8'h0C);
    idle_cyc(); exp_wr("t6_b2n", 32'h2, 8'h0B);
    idle_cyc(); exp_wr("t6_b3n", 32'h3, 8'h0A);
    idle_cyc(); exp_done("t6", 32'h4, 16'd1);

    // 7: Y86 2-byte (nibble 2) then 1-byte (nibble F), sequential
    cyc(1, 48'h0000_0000_E521, 1, 32'h0, 1, 0, 0);
    cyc(1, 48'h0000_0000_00F7, 1, 32'h0, 1, 0, 0); exp_wr("t7_b0", 32'h4, 8'h21);
    chk("t7_rdy0", {31'd0, in_ready}, 32'd0);
    cyc(1, 48'h0000_0000_00F7, 1, 32'h0, 1, 0, 0); exp_wr("t7_b1", 32'h5, 8'hE5);
    idle_cyc(); exp_wr("t7_b2", 32'h6, 8'hF7);
    idle_cyc(); exp_done("t7", 32'h7, 16'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
